// File: rtl/fifo_rd_stream_if.sv
// FIFO read-port and output-stream signals of fifo_rd_stream.
// The master modport is the consumer block; the slave side is the FIFO plus the stream sink.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side consumer: issues reads into a 3-entry buffer and re-presents the
// words as a valid/ready stream with out_last every BURST_LEN words.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic                flush,
  fifo_rd_stream_if.master    bus,
  output logic [15:0]         words_out
);

  localparam logic [15:0] BCNT_MAX = 16'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic                  inflight_q, inflight_d;
  logic [15:0]           bcnt_q, bcnt_d;
  logic [15:0]           words_q, words_d;

  logic                  accept;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Only registered occupancy, flush and reset reach rd_en, never out_ready.
  assign bus.rd_en = rd_rst_n && !flush &&
                     (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign accept    = bus.rd_en && !bus.rd_empty;
  assign capture   = inflight_q && !flush;
  assign pop       = (occ_q != 2'd0) && bus.out_ready;

  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = mem_q[head_q];
  assign bus.out_last  = (occ_q != 2'd0) && (bcnt_q == BCNT_MAX);
  assign words_out     = words_q;

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    bcnt_d     = bcnt_q;
    words_d    = words_q;
    inflight_d = accept;

    // A pop coinciding with flush was still taken by the sink, so it is counted.
    if (pop && (words_q != 16'hFFFF)) begin
      words_d = words_q + 16'd1;
    end

    if (flush) begin
      occ_d  = 2'd0;
      head_d = 2'd0;
      tail_d = 2'd0;
      bcnt_d = 16'd0;
    end else begin
      if (capture) begin
        tail_d = ptr_next(tail_q);
      end
      if (pop) begin
        head_d = ptr_next(head_q);
        bcnt_d = (bcnt_q == BCNT_MAX) ? 16'd0 : bcnt_q + 16'd1;
      end
      case ({capture, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      occ_q      <= 2'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      inflight_q <= 1'b0;
      bcnt_q     <= 16'd0;
      words_q    <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      bcnt_q     <= bcnt_d;
      words_q    <= words_d;
    end
  end

  // Storage is cleared on reset so out_data reads zero until the first capture.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture) begin
      mem_q[tail_q] <= bus.rd_data;
    end
  end

  a_no_overflow : assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd3));

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's async FIFO read port; runs entirely in the read clock domain.
- Drives rd_en and samples rd_data/rd_empty (1-cycle read latency), then re-presents the words as a valid/ready stream with burst framing.
- Contains a 3-entry output buffer so rd_en depends only on registered state. There is no combinational path from out_ready to rd_en.
- Sustains 1 word/cycle when the FIFO is non-empty and the sink is always ready.

Parameters:
- DATA_WIDTH, 32, width of a FIFO word and of out_data.
- BURST_LEN, 16, words per burst; out_last marks the final word of each burst; legal range 1..65535.

Ports:
- rd_clk  input  1  read-domain clock; all logic is on its rising edge.
- rd_rst_n  input  1  reset, asynchronous assert, active-low.
- rd_en  output  1  FIFO read request; the FIFO accepts it when rd_en && !rd_empty.
- rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- rd_empty  input  1  FIFO empty flag.
- flush  input  1  synchronous drop of buffered/in-flight words and burst-count restart.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- out_data  output  DATA_WIDTH  stream data, head of buffer.
- out_last  output  1  final word of the current burst.
- words_out  output  16  saturating count of accepted output words (status).

Behaviour:
- Reset (rd_rst_n=0, async), all of the following cleared:
  - rd_en, out_valid, out_last = 0.
  - out_data = 0; words_out = 0; burst count = 0.
  - buffer occupancy = 0; in-flight flag = 0.
- State:
  - occ: 0..3, buffer entries.
  - inflight: 1 bit, a read was accepted last cycle.
  - bcnt: 0..BURST_LEN-1.
- Read issue:
  - rd_en = !flush && (occ + inflight < 3); registered-state terms plus flush only.
  - A read is accepted when rd_en && !rd_empty. Set inflight=1 for the next cycle, otherwise 0.
- Capture:
  - When inflight=1, rd_data is written to the buffer tail that cycle.
  - Capture and pop in the same cycle leave occ unchanged. Order is preserved (circular 3-entry array, 2-bit head/tail wrap 2->0).
- Output:
  - out_valid = (occ != 0). out_data = buffer head.
  - Pop on out_valid && out_ready.
  - out_data/out_valid are held stable while out_valid && !out_ready.
- Framing:
  - out_last = out_valid && (bcnt == BURST_LEN-1).
  - On pop: bcnt = (bcnt == BURST_LEN-1) ? 0 : bcnt+1.
  - BURST_LEN=1 gives out_last on every word.
- words_out increments on each pop and saturates at 16'hFFFF.
- Overflow is impossible by construction: occ + inflight <= 3 always. Checked by assertion.
- Flush (synchronous, 1-cycle pulse or held):
  - Sets occ=0 and bcnt=0, and forces rd_en=0.
  - A word arriving from a read accepted the cycle before flush is discarded (inflight cleared).
  - out_valid=0 the cycle after flush.
  - words_out is not cleared.
  - A pop in the same cycle as flush still counts in words_out.
- rd_empty high: no read is accepted, and rd_en may remain high. Buffered words still drain.
- Reset mid-burst: buffered words are lost and bcnt restarts at 0.

Test Plan:
- Throughput: FIFO preloaded with 0x100..0x10F, out_ready=1, BURST_LEN=16:
  - First out_valid 2 cycles after reset release.
  - Then 16 consecutive words 0x100..0x10F, one per cycle.
  - out_last only on 0x10F; words_out=16.
- Backpressure: 8 words queued, out_ready=0 for 10 cycles:
  - rd_en drops after 3 reads; occ=3; out_data held at the first word.
  - Release out_ready: all 8 words emerge in order, no loss or duplicate.
- Empty gaps: FIFO written 1 word every 4 cycles, out_ready=1 -> each word is output exactly once; out_valid low between words.
- Burst wrap: BURST_LEN=3, 7 words -> out_last on words 3 and 6; bcnt=1 after word 7.
- Flush with read in flight: flush asserted the cycle after an accepted read with occ=2:
  - Next cycle out_valid=0, bcnt=0.
  - The in-flight word never appears on out_data.
  - Subsequent FIFO words stream normally.
- Async reset mid-stream: rd_rst_n low between clock edges -> rd_en, out_valid, out_last and words_out go to 0 immediately, without waiting for a clock edge.
